// File: rtl/ballot_controller_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : ballot_controller_pkg                                        |
// | Description : Shared types, defaults and helpers for the ballot controller |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
package ballot_controller_pkg;

  // Ballot sequencing states
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARMED   = 2'd1,
    COMMIT  = 2'd2,
    CONFIRM = 2'd3
  } state_e;

  // Index width for a given candidate count (at least one bit)
  function automatic int cand_idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int BC_NUM_CAND    = 4;
  localparam int BC_CAND_IDX_W  = cand_idx_w(BC_NUM_CAND);

  // Increment that sticks at max_val instead of wrapping
  function automatic logic [31:0] sat_inc(input logic [31:0] val, input logic [31:0] max_val);
    return (val >= max_val) ? val : val + 32'd1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/ballot_controller_sat_counter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : sat_counter                                                  |
// | Description : Enable-driven statistics counter that saturates at all-ones  |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module sat_counter
  import ballot_controller_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             en_i,
  output logic [CNT_W-1:0] count_o
);

  localparam logic [CNT_W-1:0] MAX_VAL = '1;

  logic [CNT_W-1:0] count_q, count_d;

  // Next count: bump by one when enabled, holding at the ceiling
  always_comb begin
    count_d = count_q;
    if (en_i) begin
      count_d = CNT_W'(sat_inc(32'(count_q), 32'(MAX_VAL)));
    end
  end

  // Count register with asynchronous clear
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;

endmodule
`default_nettype wire

// File: rtl/ballot_controller.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : ballot_controller                                            |
// | Description : Issues one ballot per officer arm, forwards a single         |
// |               unambiguous press as a one-hot strobe, shows confirmation    |
// |               and keeps cast / expired / rejected statistics.             |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module ballot_controller
  import ballot_controller_pkg::*;
#(
  parameter int NUM_CAND       = BC_NUM_CAND,
  parameter int TIMEOUT_CYCLES = 1000,
  parameter int HOLD_CYCLES    = 50,
  parameter int CNT_W          = 8,
  localparam int IDX_W         = cand_idx_w(NUM_CAND)
) (
  input  logic                clock_i,
  input  logic                reset_ni,
  input  logic                mode_i,
  input  logic                arm_i,
  input  logic [NUM_CAND-1:0] vote_req_i,
  output logic [NUM_CAND-1:0] cand_vote_valid_o,
  output logic                ballot_ready_o,
  output logic                confirm_o,
  output logic [IDX_W-1:0]    confirm_cand_o,
  output logic [CNT_W-1:0]    ballots_cast_o,
  output logic [CNT_W-1:0]    ballots_expired_o,
  output logic [CNT_W-1:0]    rejected_presses_o
);

  localparam int TMR_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam int HLD_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYCLES - 1);
  localparam logic [HLD_W-1:0] HLD_LAST = HLD_W'(HOLD_CYCLES - 1);

  state_e              state_q, state_d;
  logic [TMR_W-1:0]    timer_q, timer_d;
  logic [HLD_W-1:0]    hold_q, hold_d;
  logic [IDX_W-1:0]    cand_q, cand_d;
  logic [NUM_CAND-1:0] strobe_q, strobe_d;
  logic                ready_q, ready_d;
  logic                confirm_q, confirm_d;

  logic                req_any;
  logic                req_one;
  logic [IDX_W-1:0]    req_idx;
  logic                expired_en;
  logic                rejected_en;
  logic                cast_en;

  // Classify the request lines: any bit, exactly one bit, and its index
  always_comb begin
    req_any = |vote_req_i;
    req_one = req_any && ((vote_req_i & (vote_req_i - NUM_CAND'(1))) == '0);
    req_idx = '0;
    for (int i = 0; i < NUM_CAND; i++) begin
      if (vote_req_i[i]) begin
        req_idx = IDX_W'(i);
      end
    end
  end

  // Next-state, timers and statistic enables
  always_comb begin
    state_d     = state_q;
    timer_d     = timer_q;
    hold_d      = hold_q;
    cand_d      = cand_q;
    expired_en  = 1'b0;
    rejected_en = 1'b0;

    case (state_q)
      IDLE: begin
        rejected_en = req_any;
        if (arm_i && !mode_i) begin
          state_d = ARMED;
          timer_d = '0;
        end
      end

      ARMED: begin
        if (req_one) begin
          // A clean press wins over cancel and expiry in the same cycle
          state_d = COMMIT;
          cand_d  = req_idx;
        end else if (req_any) begin
          // Ambiguous press: refuse it but keep the ballot alive; the timer
          // keeps running and sticks at its last value so expiry still follows
          rejected_en = 1'b1;
          if (timer_q != TMR_LAST) begin
            timer_d = timer_q + TMR_W'(1);
          end
        end else if (mode_i) begin
          state_d    = IDLE;
          expired_en = 1'b1;
        end else if (timer_q == TMR_LAST) begin
          state_d    = IDLE;
          expired_en = 1'b1;
        end else begin
          timer_d = timer_q + TMR_W'(1);
        end
      end

      COMMIT: begin
        rejected_en = req_any;
        state_d     = CONFIRM;
        hold_d      = '0;
      end

      CONFIRM: begin
        rejected_en = req_any;
        if (hold_q == HLD_LAST) begin
          state_d = IDLE;
        end else begin
          hold_d = hold_q + HLD_W'(1);
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Registered output values; the strobe follows the COMMIT cycle by one
  always_comb begin
    ready_d   = (state_d == ARMED);
    confirm_d = (state_d == CONFIRM);
    strobe_d  = '0;
    if (state_q == COMMIT) begin
      strobe_d = NUM_CAND'(1) << cand_q;
    end
  end

  // State, timer and output registers with asynchronous clear
  always_ff @(posedge clock_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q   <= IDLE;
      timer_q   <= '0;
      hold_q    <= '0;
      cand_q    <= '0;
      strobe_q  <= '0;
      ready_q   <= 1'b0;
      confirm_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      timer_q   <= timer_d;
      hold_q    <= hold_d;
      cand_q    <= cand_d;
      strobe_q  <= strobe_d;
      ready_q   <= ready_d;
      confirm_q <= confirm_d;
    end
  end

  // A cast is counted on the edge that ends the strobe cycle
  assign cast_en = |strobe_q;

  sat_counter #(.CNT_W(CNT_W)) u_cnt_cast (
    .clk_i   (clock_i),
    .rst_ni  (reset_ni),
    .en_i    (cast_en),
    .count_o (ballots_cast_o)
  );

  sat_counter #(.CNT_W(CNT_W)) u_cnt_expired (
    .clk_i   (clock_i),
    .rst_ni  (reset_ni),
    .en_i    (expired_en),
    .count_o (ballots_expired_o)
  );

  sat_counter #(.CNT_W(CNT_W)) u_cnt_rejected (
    .clk_i   (clock_i),
    .rst_ni  (reset_ni),
    .en_i    (rejected_en),
    .count_o (rejected_presses_o)
  );

  assign cand_vote_valid_o = strobe_q;
  assign ballot_ready_o    = ready_q;
  assign confirm_o         = confirm_q;
  assign confirm_cand_o    = cand_q;

endmodule
`default_nettype wire

// File: tb/tb_ballot_controller.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_ballot_controller                                         |
// | Description : Self-checking bench: vector table, scoreboard of strobes,    |
// |               hand sequences for timeout, confirm abuse, saturation, reset |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_ballot_controller;

  localparam int TO   = 1000;
  localparam int HOLD = 50;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       mode_i = 1'b0;
  logic       arm_i = 1'b0;
  logic [3:0] vote_req_i = 4'b0;
  logic [3:0] cand_vote_valid_o;
  logic       ballot_ready_o;
  logic       confirm_o;
  logic [1:0] confirm_cand_o;
  logic [7:0] ballots_cast_o;
  logic [7:0] ballots_expired_o;
  logic [7:0] rejected_presses_o;

  ballot_controller #(
    .NUM_CAND       (4),
    .TIMEOUT_CYCLES (TO),
    .HOLD_CYCLES    (HOLD),
    .CNT_W          (8)
  ) dut (
    .clock_i            (clk),
    .reset_ni           (rst_n),
    .mode_i             (mode_i),
    .arm_i              (arm_i),
    .vote_req_i         (vote_req_i),
    .cand_vote_valid_o  (cand_vote_valid_o),
    .ballot_ready_o     (ballot_ready_o),
    .confirm_o          (confirm_o),
    .confirm_cand_o     (confirm_cand_o),
    .ballots_cast_o     (ballots_cast_o),
    .ballots_expired_o  (ballots_expired_o),
    .rejected_presses_o (rejected_presses_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] strobe;
    logic [1:0] idx;
  } sb_t;

  typedef struct {
    logic [3:0] req;
    logic       mode;
    logic       accept;
    logic [1:0] idx;
  } vec_t;

  sb_t  sb_q[$];
  vec_t vecs[7];

  int total = 0;
  int bad = 0;
  int exp_cast = 0;
  int exp_expired = 0;
  int exp_rej = 0;
  int conf_total = 0;
  logic [3:0] prev_strobe = 4'b0;

  function automatic int sat8(input int v);
    return (v >= 255) ? 255 : v + 1;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_arm();
    arm_i = 1'b1;
    cyc(1);
    arm_i = 1'b0;
    chk("ready_after_arm", ballot_ready_o, 1);
  endtask

  // Wait for the confirmation window to close, bounded
  task automatic wait_done();
    int  n;
    logic ok;
    n  = 0;
    ok = 1'b0;
    while (n < 200 && !ok) begin
      cyc(1);
      n++;
      if (n > 1 && !confirm_o && !ballot_ready_o) ok = 1'b1;
    end
    chk("vote_done_in_time", ok, 1);
  endtask

  // Assumes ARMED; drives one press cycle and follows the ballot to IDLE
  task automatic vote_accept(input logic [3:0] req, input logic [1:0] idx, input logic md);
    int c0;
    sb_q.push_back('{req, idx});
    c0 = conf_total;
    vote_req_i = req;
    mode_i     = md;
    cyc(1);
    vote_req_i = 4'b0;
    mode_i     = 1'b0;
    chk("ready_low_in_commit", ballot_ready_o, 0);
    exp_cast = sat8(exp_cast);
    wait_done();
    chk("confirm_len", conf_total - c0, HOLD);
    chk("ballots_cast", ballots_cast_o, exp_cast);
    chk("confirm_cand", confirm_cand_o, idx);
    chk("rejected_unchanged", rejected_presses_o, exp_rej);
  endtask

  initial begin
    vecs[0] = '{4'b0100, 1'b0, 1'b1, 2'd2};
    vecs[1] = '{4'b0001, 1'b1, 1'b1, 2'd0};
    vecs[2] = '{4'b1000, 1'b0, 1'b1, 2'd3};
    vecs[3] = '{4'b0010, 1'b1, 1'b1, 2'd1};
    vecs[4] = '{4'b0011, 1'b0, 1'b0, 2'd0};
    vecs[5] = '{4'b1111, 1'b1, 1'b0, 2'd0};
    vecs[6] = '{4'b1010, 1'b0, 1'b0, 2'd0};

    // Strobe scoreboard and invariant monitor, sampling on the falling edge
    fork
      forever begin
        @(negedge clk);
        if (rst_n) begin
          if (confirm_o) conf_total++;
          if (ballot_ready_o && confirm_o) chk("ready_confirm_exclusive", 1, 0);
          if (cand_vote_valid_o != 4'b0) begin
            chk("strobe_onehot", $countones(cand_vote_valid_o), 1);
            chk("strobe_single_cycle", prev_strobe, 0);
            if (sb_q.size() == 0) begin
              chk("unexpected_strobe", cand_vote_valid_o, 0);
            end else begin
              sb_t e;
              e = sb_q.pop_front();
              chk("strobe_value", cand_vote_valid_o, e.strobe);
              chk("strobe_cand", confirm_cand_o, e.idx);
            end
          end
          prev_strobe = cand_vote_valid_o;
        end else begin
          prev_strobe = 4'b0;
        end
      end
    join_none

    // Reset state
    cyc(3);
    chk("rst_strobe", cand_vote_valid_o, 0);
    chk("rst_ready", ballot_ready_o, 0);
    chk("rst_confirm", confirm_o, 0);
    chk("rst_cand", confirm_cand_o, 0);
    chk("rst_cast", ballots_cast_o, 0);
    chk("rst_expired", ballots_expired_o, 0);
    chk("rst_rejected", rejected_presses_o, 0);
    rst_n = 1'b1;
    cyc(2);

    // Table-driven ballots
    for (int i = 0; i < 7; i++) begin
      do_arm();
      if (vecs[i].accept) begin
        vote_accept(vecs[i].req, vecs[i].idx, vecs[i].mode);
        chk("expired_unchanged", ballots_expired_o, exp_expired);
      end else begin
        vote_req_i = vecs[i].req;
        mode_i     = vecs[i].mode;
        cyc(1);
        vote_req_i = 4'b0;
        mode_i     = 1'b0;
        exp_rej = sat8(exp_rej);
        chk("ambig_rejected", rejected_presses_o, exp_rej);
        chk("ambig_still_ready", ballot_ready_o, 1);
        chk("ambig_no_expire", ballots_expired_o, exp_expired);
        mode_i = 1'b1;
        cyc(1);
        mode_i = 1'b0;
        exp_expired = sat8(exp_expired);
        chk("cancel_ready", ballot_ready_o, 0);
        chk("cancel_expired", ballots_expired_o, exp_expired);
        cyc(2);
      end
    end

    // Ambiguous then clean press within one ballot
    do_arm();
    vote_req_i = 4'b0011;
    cyc(1);
    vote_req_i = 4'b0;
    exp_rej = sat8(exp_rej);
    chk("seq_ambig_rej", rejected_presses_o, exp_rej);
    chk("seq_ambig_ready", ballot_ready_o, 1);
    vote_accept(4'b0001, 2'd0, 1'b0);

    // Timeout with no press, then a press in IDLE
    do_arm();
    cyc(TO - 1);
    chk("timeout_ready_last", ballot_ready_o, 1);
    cyc(1);
    exp_expired = sat8(exp_expired);
    chk("timeout_ready", ballot_ready_o, 0);
    chk("timeout_expired", ballots_expired_o, exp_expired);
    vote_req_i = 4'b0001;
    cyc(1);
    vote_req_i = 4'b0;
    exp_rej = sat8(exp_rej);
    chk("idle_press_rej", rejected_presses_o, exp_rej);
    cyc(3);

    // Clean press in the exact expiry cycle is accepted
    do_arm();
    cyc(TO - 1);
    vote_accept(4'b0010, 2'd1, 1'b0);
    chk("expiry_press_no_expire", ballots_expired_o, exp_expired);

    // Arm while in result mode is ignored
    mode_i = 1'b1;
    arm_i  = 1'b1;
    cyc(1);
    arm_i = 1'b0;
    chk("arm_mode1_ready", ballot_ready_o, 0);
    cyc(2);
    chk("arm_mode1_ready_later", ballot_ready_o, 0);
    mode_i = 1'b0;

    // Presses, arm and mode during COMMIT/CONFIRM
    begin
      int c0;
      do_arm();
      sb_q.push_back('{4'b1000, 2'd3});
      c0 = conf_total;
      vote_req_i = 4'b1000;
      cyc(1);
      vote_req_i = 4'b1111;
      arm_i      = 1'b1;
      mode_i     = 1'b1;
      cyc(10);
      vote_req_i = 4'b0;
      arm_i      = 1'b0;
      mode_i     = 1'b0;
      for (int k = 0; k < 10; k++) exp_rej = sat8(exp_rej);
      exp_cast = sat8(exp_cast);
      chk("confirm_abuse_rej", rejected_presses_o, exp_rej);
      wait_done();
      chk("confirm_abuse_len", conf_total - c0, HOLD);
      chk("confirm_abuse_cast", ballots_cast_o, exp_cast);
      cyc(2);
      chk("confirm_abuse_not_rearmed", ballot_ready_o, 0);
    end

    // Saturation of ballots_cast
    for (int i = 0; i < 300; i++) begin
      logic [1:0] idx;
      logic [3:0] req;
      idx = 2'(i % 4);
      req = 4'b0001 << idx;
      do_arm();
      vote_accept(req, idx, 1'b0);
    end
    chk("cast_saturated", ballots_cast_o, 255);

    // Asynchronous reset in the middle of an armed ballot
    do_arm();
    cyc(3);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_ready", ballot_ready_o, 0);
    chk("async_rst_strobe", cand_vote_valid_o, 0);
    chk("async_rst_confirm", confirm_o, 0);
    chk("async_rst_cand", confirm_cand_o, 0);
    chk("async_rst_cast", ballots_cast_o, 0);
    chk("async_rst_expired", ballots_expired_o, 0);
    chk("async_rst_rejected", rejected_presses_o, 0);
    cyc(2);
    rst_n = 1'b1;
    cyc(3);
    chk("post_rst_expired", ballots_expired_o, 0);

    chk("scoreboard_drained", sb_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Absolute guard so the run always ends
  initial begin
    #2000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "global timeout");
  end

endmodule
`default_nettype wire
